// File: rtl/pcm_ctrl_pkg.sv
// Shared types and widths for the PCM rate controller.
package pcm_ctrl_pkg;

    localparam int unsigned PCM_W  = 24;
    localparam int unsigned UCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/pcm_rate_ctrl_strobe.sv
// rate_strobe_gen: free-running divider producing coincident en_8/en_16/en_32 strobes.
module rate_strobe_gen #(
    parameter int unsigned DIV_LOG2 = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic en_8,
    output logic en_16,
    output logic en_32,
    output logic wrap_c
);

    localparam int unsigned CNT_W = DIV_LOG2 + 2;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_W'(1);
    // High in the cycle before en_32 rises, i.e. on the edge that asserts it.
    assign wrap_c  = &cnt_inc;

    // Strobes decode the incremented count so each one is high while cnt matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            en_8  <= 1'b0;
            en_16 <= 1'b0;
            en_32 <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            en_8  <= 1'b0;
            en_16 <= 1'b0;
            en_32 <= 1'b0;
        end else if (run) begin
            cnt   <= cnt_inc;
            en_8  <= &cnt_inc[DIV_LOG2-1:0];
            en_16 <= &cnt_inc[DIV_LOG2:0];
            en_32 <= &cnt_inc;
        end else begin
            en_8  <= 1'b0;
            en_16 <= 1'b0;
            en_32 <= 1'b0;
        end
    end

endmodule

// File: rtl/pcm_rate_ctrl.sv
// PCM sample rate controller: one-entry hold, en_32-paced output, drain of zeros after stop.
// Optional underrun_cnt output enabled by defining PCM_RATE_CTRL_UNDERRUN_CNT_EN.
module pcm_rate_ctrl
    import pcm_ctrl_pkg::*;
#(
    parameter int unsigned DIV_LOG2      = 3,
    parameter int unsigned DRAIN_PERIODS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pcm_valid,
    input  logic [PCM_W-1:0] pcm_data,
    output logic             pcm_ready,
    output logic [PCM_W-1:0] pcm_out,
    output logic             en_32,
    output logic             en_16,
    output logic             en_8,
    output logic             busy,
    output logic             underrun
`ifdef PCM_RATE_CTRL_UNDERRUN_CNT_EN
   ,output logic [UCNT_W-1:0] underrun_cnt
`endif
);

    localparam int unsigned DCNT_W = $clog2(DRAIN_PERIODS + 1);

    state_e             state;
    state_e             state_nxt;
    logic [PCM_W-1:0]   hold;
    logic               full;
    logic [DCNT_W-1:0]  drain_cnt;
    logic               wrap_c;
    logic               xfer_c;
    logic               accept_c;
    logic               prime_c;
    logic               drain_entry_c;
    logic               drain_done_c;

    rate_strobe_gen #(.DIV_LOG2(DIV_LOG2)) u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_nxt == IDLE),
        .run    (state != IDLE),
        .en_8   (en_8),
        .en_16  (en_16),
        .en_32  (en_32),
        .wrap_c (wrap_c)
    );

    assign xfer_c        = (state == RUN) && wrap_c;
    assign pcm_ready     = ((state == PRIME) || (state == RUN)) && (!full || xfer_c);
    assign accept_c      = pcm_valid && pcm_ready;
    assign prime_c       = (state == IDLE) && start;
    assign drain_entry_c = (state == RUN) && !start;
    assign drain_done_c  = (state == DRAIN) && en_32 &&
                           (drain_cnt == DCNT_W'(DRAIN_PERIODS - 1));

    // Next-state decode; start is ignored while draining.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PRIME;
            PRIME:   if (!start) state_nxt = IDLE;
                     else if (accept_c) state_nxt = RUN;
            RUN:     if (!start) state_nxt = DRAIN;
            DRAIN:   if (drain_done_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            hold      <= '0;
            full      <= 1'b0;
            pcm_out   <= '0;
            underrun  <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);

            // Hold register: flushed on drain entry or stop, otherwise refilled by accepts.
            if ((state_nxt == IDLE) || drain_entry_c) begin
                hold <= '0;
                full <= 1'b0;
            end else if (xfer_c) begin
                full <= accept_c;
                if (accept_c) hold <= pcm_data;
            end else if (accept_c) begin
                hold <= pcm_data;
                full <= 1'b1;
            end

            if (prime_c) begin
                pcm_out  <= '0;
                underrun <= 1'b0;
            end else if (xfer_c) begin
                pcm_out <= full ? hold : '0;
                if (!full) underrun <= 1'b1;
            end else if ((state == DRAIN) && wrap_c) begin
                pcm_out <= '0;
            end

            if (drain_entry_c) drain_cnt <= '0;
            else if ((state == DRAIN) && en_32) drain_cnt <= drain_cnt + DCNT_W'(1);
        end
    end

`ifdef PCM_RATE_CTRL_UNDERRUN_CNT_EN
    // Saturating count of transfers that found the hold empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (prime_c) begin
            underrun_cnt <= '0;
        end else if (xfer_c && !full && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pcm_rate_ctrl.sv
// Directed self-checking bench for pcm_rate_ctrl (DIV_LOG2=3, DRAIN_PERIODS=4).
module tb_pcm_rate_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pcm_valid;
    logic [23:0] pcm_data;
    logic        pcm_ready;
    logic [23:0] pcm_out;
    logic        en_32;
    logic        en_16;
    logic        en_8;
    logic        busy;
    logic        underrun;
`ifdef PCM_RATE_CTRL_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int          vectors;
    int          miscompares;
    int          cyc;
    logic        feed_en;
    logic [23:0] next_data;

    pcm_rate_ctrl #(.DIV_LOG2(3), .DRAIN_PERIODS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pcm_valid (pcm_valid),
        .pcm_data  (pcm_data),
        .pcm_ready (pcm_ready),
        .pcm_out   (pcm_out),
        .en_32     (en_32),
        .en_16     (en_16),
        .en_8      (en_8),
        .busy      (busy),
`ifdef PCM_RATE_CTRL_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive the source, note whether the coming edge accepts, sample at negedge.
    task automatic step();
        logic acc;
        pcm_valid = feed_en;
        pcm_data  = next_data;
        #1;
        acc = pcm_valid && pcm_ready;
        @(negedge clk);
        cyc++;
        if (acc) next_data = next_data + 24'd1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; feed_en = 1'b0; next_data = 24'h800000;
        pcm_valid = 1'b0; pcm_data = '0; cyc = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pcm_ready, en_32, en_16, en_8, busy, underrun, pcm_out} !== 30'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b_%h want all zero",
                     {pcm_ready, en_32, en_16, en_8, busy, underrun}, pcm_out);
        end
        rst_n = 1'b1;
        step(); step();
        vectors++;
        if ({busy, en_8, pcm_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_quiet: busy/en_8/ready got %b want 000", {busy, en_8, pcm_ready});
        end
    endtask

    task automatic test_strobe_periods();
        feed_en = 1'b1; start = 1'b1; cyc = 0;
        while (cyc < 100) begin
            step();
            vectors++;
            if ({en_32, en_16, en_8} !== {(cyc % 32) == 0, (cyc % 16) == 0, (cyc % 8) == 0}) begin
                miscompares++;
                $display("FAIL strobe_pattern cyc=%0d: en32/16/8 got %b want %b", cyc,
                         {en_32, en_16, en_8},
                         {(cyc % 32) == 0, (cyc % 16) == 0, (cyc % 8) == 0});
            end
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_running: got %b want 1", busy);
        end
    endtask

    task automatic test_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({pcm_ready, en_32, en_16, en_8, busy, underrun, pcm_out} !== 30'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %b_%h want all zero",
                     {pcm_ready, en_32, en_16, en_8, busy, underrun}, pcm_out);
        end
        @(negedge clk);
        next_data = 24'h000001;
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 8) begin
            step();
            vectors++;
            if ({en_32, en_16, en_8} !== {2'b00, cyc == 8}) begin
                miscompares++;
                $display("FAIL first_en8 cyc=%0d: en32/16/8 got %b want %b", cyc,
                         {en_32, en_16, en_8}, {2'b00, cyc == 8});
            end
            if (cyc == 1) begin
                vectors++;
                if ({busy, pcm_ready, pcm_out} !== {2'b11, 24'd0}) begin
                    miscompares++;
                    $display("FAIL prime_state: busy/ready/out got %b/%b/%h want 1/1/000000",
                             busy, pcm_ready, pcm_out);
                end
            end
        end
    endtask

    task automatic test_latency();
        run_to(31);
        vectors++;
        if ({pcm_ready, en_32, pcm_out} !== {2'b10, 24'd0}) begin
            miscompares++;
            $display("FAIL pre_first_xfer: ready/en32/out got %b/%b/%h want 1/0/000000",
                     pcm_ready, en_32, pcm_out);
        end
        run_to(32);
        vectors++;
        if ({en_32, pcm_out} !== {1'b1, 24'h000001}) begin
            miscompares++;
            $display("FAIL sample1: en32/out got %b/%h want 1/000001", en_32, pcm_out);
        end
        run_to(64);
        feed_en = 1'b0;
        vectors++;
        if ({en_32, pcm_out} !== {1'b1, 24'h000002}) begin
            miscompares++;
            $display("FAIL sample2: en32/out got %b/%h want 1/000002", en_32, pcm_out);
        end
        run_to(96);
        vectors++;
        if ({en_32, underrun, pcm_out} !== {2'b10, 24'h000003}) begin
            miscompares++;
            $display("FAIL sample3: en32/underrun/out got %b/%b/%h want 1/0/000003",
                     en_32, underrun, pcm_out);
        end
    endtask

    task automatic test_underrun();
        run_to(128);
        feed_en = 1'b1;
        vectors++;
        if ({en_32, underrun, pcm_out} !== {2'b11, 24'd0}) begin
            miscompares++;
            $display("FAIL underrun_event: en32/underrun/out got %b/%b/%h want 1/1/000000",
                     en_32, underrun, pcm_out);
        end
        run_to(160);
        vectors++;
        if ({underrun, pcm_out} !== {1'b1, 24'h000004}) begin
            miscompares++;
            $display("FAIL underrun_sticky: underrun/out got %b/%h want 1/000004", underrun, pcm_out);
        end
`ifdef PCM_RATE_CTRL_UNDERRUN_CNT_EN
        vectors++;
        if (underrun_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL underrun_cnt: got %0d want 1", underrun_cnt);
        end
`endif
    endtask

    task automatic test_drain();
        int pulses;
        int idle_at;
        pulses = 0;
        idle_at = -1;
        run_to(170);
        start = 1'b0;
        while (cyc < 320) begin
            step();
            if (en_32) begin
                pulses++;
                vectors++;
                if (pcm_out !== 24'd0) begin
                    miscompares++;
                    $display("FAIL drain_zero cyc=%0d: out got %h want 000000", cyc, pcm_out);
                end
            end
            if (idle_at < 0 && busy === 1'b0) idle_at = cyc;
            if (idle_at >= 0) begin
                vectors++;
                if ({en_32, en_16, en_8, pcm_ready, busy} !== 5'b00000) begin
                    miscompares++;
                    $display("FAIL idle_after_drain cyc=%0d: en32/16/8/ready/busy got %b want 00000",
                             cyc, {en_32, en_16, en_8, pcm_ready, busy});
                end
            end
        end
        vectors++;
        if (pulses != 4) begin
            miscompares++;
            $display("FAIL drain_pulses: got %0d want 4", pulses);
        end
        vectors++;
        if (idle_at != 289) begin
            miscompares++;
            $display("FAIL drain_exit_cycle: got %0d want 289", idle_at);
        end
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_held_idle: got %b want 1", underrun);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        cyc = 0;
        next_data = 24'h000100;
        step();
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_clear: got %b want 0", underrun);
        end
`ifdef PCM_RATE_CTRL_UNDERRUN_CNT_EN
        vectors++;
        if (underrun_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL underrun_cnt_clear: got %0d want 0", underrun_cnt);
        end
`endif
        run_to(31);
        vectors++;
        if (pcm_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_on_xfer_full: got %b want 1", pcm_ready);
        end
        run_to(32);
        vectors++;
        if ({en_32, pcm_ready, pcm_out} !== {2'b10, 24'h000100}) begin
            miscompares++;
            $display("FAIL simul_old_out: en32/ready/out got %b/%b/%h want 1/0/000100",
                     en_32, pcm_ready, pcm_out);
        end
        run_to(63);
        vectors++;
        if (pcm_out !== 24'h000100) begin
            miscompares++;
            $display("FAIL no_dup_hold: out got %h want 000100", pcm_out);
        end
        run_to(64);
        vectors++;
        if (pcm_out !== 24'h000101) begin
            miscompares++;
            $display("FAIL simul_new_out: out got %h want 000101", pcm_out);
        end
        run_to(96);
        vectors++;
        if ({underrun, pcm_out} !== {1'b0, 24'h000102}) begin
            miscompares++;
            $display("FAIL simul_third: underrun/out got %b/%h want 0/000102", underrun, pcm_out);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_strobe_periods();
        test_reset_mid();
        test_latency();
        test_underrun();
        test_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
